// File: rtl/id_stage_pkg.sv
// Shared decode constants and ALU control payload for the decode stage and the ALU driver.
package id_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SLT = 3'b001,
    SLL = 3'b010,
    SRL = 3'b011,
    XOR = 3'b100,
    OR  = 3'b101,
    AND = 3'b110
  } alu_opsel_e;

  typedef struct packed {
    alu_opsel_e opsel;
    logic       sub;
    logic       is_unsigned;
    logic       arith;
  } alu_ctrl_t;

  // RV32I funct3 -> ALU operation select (shared by OP and OP-IMM).
  function automatic alu_opsel_e funct3_to_opsel(input logic [2:0] funct3);
    alu_opsel_e sel;
    case (funct3)
      3'b000:  sel = ADD;
      3'b001:  sel = SLL;
      3'b010:  sel = SLT;
      3'b011:  sel = SLT;
      3'b100:  sel = XOR;
      3'b101:  sel = SRL;
      3'b110:  sel = OR;
      default: sel = AND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 integer register file: two combinational read ports, one write port, optional write-to-read bypass.
module regfile
  import id_stage_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [XLEN-1:0]   o_rdata1_c,
  output logic [XLEN-1:0]   o_rdata2_c,
  input  logic              i_wen,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata
);

  logic [XLEN-1:0] regs_q [NREGS];

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (i_wen && (i_waddr != '0)) begin
      regs_q[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1_c = '0;
    o_rdata2_c = '0;
    if (i_raddr1 != '0) begin
      o_rdata1_c = regs_q[i_raddr1];
      if (BYPASS_EN && i_wen && (i_waddr == i_raddr1)) o_rdata1_c = i_wdata;
    end
    if (i_raddr2 != '0) begin
      o_rdata2_c = regs_q[i_raddr2];
      if (BYPASS_EN && i_wen && (i_waddr == i_raddr2)) o_rdata2_c = i_wdata;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode / register-read stage: decodes OP, OP-IMM, LUI, AUIPC and registers ALU controls and operands.
module id_stage
  import id_stage_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inst_valid,
  input  logic [XLEN-1:0]   i_inst,
  input  logic [XLEN-1:0]   i_pc,
  output logic              o_inst_ready,
  input  logic              i_rd_wen,
  input  logic [REG_AW-1:0] i_rd_waddr,
  input  logic [XLEN-1:0]   i_rd_wdata,
  output logic              o_ex_valid,
  input  logic              i_ex_ready,
  output logic [2:0]        o_ex_opsel,
  output logic              o_ex_sub,
  output logic              o_ex_unsigned,
  output logic              o_ex_arith,
  output logic [XLEN-1:0]   o_ex_op1,
  output logic [XLEN-1:0]   o_ex_op2,
  output logic              o_ex_rd_wen,
  output logic [REG_AW-1:0] o_ex_rd_waddr,
  output logic [XLEN-1:0]   o_ex_pc,
  output logic              o_ex_illegal
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   imm_u;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;

  assign opcode = i_inst[6:0];
  assign rd     = i_inst[11:7];
  assign funct3 = i_inst[14:12];
  assign rs1    = i_inst[19:15];
  assign rs2    = i_inst[24:20];
  assign funct7 = i_inst[31:25];
  assign imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
  assign imm_u  = {i_inst[31:12], 12'b0};

  regfile #(
    .BYPASS_EN (BYPASS_EN)
  ) u_regfile (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_raddr1   (rs1),
    .i_raddr2   (rs2),
    .o_rdata1_c (rs1_data),
    .o_rdata2_c (rs2_data),
    .i_wen      (i_rd_wen),
    .i_waddr    (i_rd_waddr),
    .i_wdata    (i_rd_wdata)
  );

  alu_ctrl_t       dec_ctrl;
  logic [XLEN-1:0] dec_op1;
  logic [XLEN-1:0] dec_op2;
  logic            dec_legal;
  logic            dec_shift;

  // Instruction decode; illegal encodings collapse to an all-zero payload.
  always_comb begin
    dec_ctrl  = '0;
    dec_op1   = '0;
    dec_op2   = '0;
    dec_legal = 1'b0;
    dec_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    case (opcode)
      OP: begin
        dec_legal = (funct7 == F7_ZERO) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec_ctrl.opsel       = funct3_to_opsel(funct3);
        dec_ctrl.sub         = (funct3 == 3'b000) && funct7[5];
        dec_ctrl.is_unsigned = (funct3 == 3'b011);
        dec_ctrl.arith       = (funct3 == 3'b101) && funct7[5];
        dec_op1              = rs1_data;
        dec_op2              = rs2_data;
      end
      OP_IMM: begin
        dec_legal = !dec_shift || (funct7 == F7_ZERO) ||
                    ((funct3 == 3'b101) && (funct7 == F7_ALT));
        dec_ctrl.opsel       = funct3_to_opsel(funct3);
        dec_ctrl.is_unsigned = (funct3 == 3'b011);
        dec_ctrl.arith       = (funct3 == 3'b101) && i_inst[30];
        dec_op1              = rs1_data;
        dec_op2              = dec_shift ? {27'b0, rs2} : imm_i;
      end
      LUI: begin
        dec_legal = 1'b1;
        dec_op2   = imm_u;
      end
      AUIPC: begin
        dec_legal = 1'b1;
        dec_op1   = i_pc;
        dec_op2   = imm_u;
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_ctrl = '0;
      dec_op1  = '0;
      dec_op2  = '0;
    end
  end

  logic              ex_valid_q,   ex_valid_d;
  alu_ctrl_t         ctrl_q,       ctrl_d;
  logic [XLEN-1:0]   op1_q,        op1_d;
  logic [XLEN-1:0]   op2_q,        op2_d;
  logic              rd_wen_q,     rd_wen_d;
  logic [REG_AW-1:0] rd_waddr_q,   rd_waddr_d;
  logic [XLEN-1:0]   pc_q,         pc_d;
  logic              illegal_q,    illegal_d;
  logic              accept;

  assign o_inst_ready = !ex_valid_q || i_ex_ready;
  assign accept       = i_inst_valid && o_inst_ready;

  // Payload register next state: load on accept, drain when consumed, otherwise hold.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ctrl_d     = ctrl_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    rd_wen_d   = rd_wen_q;
    rd_waddr_d = rd_waddr_q;
    pc_d       = pc_q;
    illegal_d  = illegal_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      ctrl_d     = dec_ctrl;
      op1_d      = dec_op1;
      op2_d      = dec_op2;
      rd_wen_d   = dec_legal && (rd != '0);
      rd_waddr_d = rd;
      pc_d       = i_pc;
      illegal_d  = !dec_legal;
    end else if (i_ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      rd_wen_q   <= 1'b0;
      rd_waddr_q <= '0;
      pc_q       <= '0;
      illegal_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ctrl_q     <= ctrl_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      rd_wen_q   <= rd_wen_d;
      rd_waddr_q <= rd_waddr_d;
      pc_q       <= pc_d;
      illegal_q  <= illegal_d;
    end
  end

  assign o_ex_valid    = ex_valid_q;
  assign o_ex_opsel    = ctrl_q.opsel;
  assign o_ex_sub      = ctrl_q.sub;
  assign o_ex_unsigned = ctrl_q.is_unsigned;
  assign o_ex_arith    = ctrl_q.arith;
  assign o_ex_op1      = op1_q;
  assign o_ex_op2      = op2_q;
  assign o_ex_rd_wen   = rd_wen_q;
  assign o_ex_rd_waddr = rd_waddr_q;
  assign o_ex_pc       = pc_q;
  assign o_ex_illegal  = illegal_q;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode / register-read stage directly upstream of the `alu`. Accepts one RV32I instruction per cycle over a valid/ready handshake, decodes it, reads operands from an integrated 32x32 register file, and presents registered ALU controls and operands to the execute stage. Scope is OP, OP-IMM, LUI and AUIPC; every other opcode is flagged illegal. Writeback enters through a dedicated write port.

## Interface
- `BYPASS_EN`, default 1: when 1, a same-cycle writeback to a source register forwards `i_rd_wdata` into the operand read.
- `i_clk` in 1: single clock; all state updates on rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_inst_valid` in 1: instruction valid from fetch.
- `i_inst` in 32: instruction word.
- `i_pc` in 32: instruction PC.
- `o_inst_ready` out 1: stage can accept.
- `i_rd_wen` in 1: writeback enable.
- `i_rd_waddr` in 5: writeback register.
- `i_rd_wdata` in 32: writeback data.
- `o_ex_valid` out 1: execute payload valid.
- `i_ex_ready` in 1: execute can accept.
- `o_ex_opsel` out 3, `o_ex_sub`, `o_ex_unsigned`, `o_ex_arith` out 1 each: ALU controls, same encoding as `alu`.
- `o_ex_op1`, `o_ex_op2` out 32: ALU operands.
- `o_ex_rd_wen` out 1, `o_ex_rd_waddr` out 5: destination for writeback.
- `o_ex_pc` out 32: PC carried forward.
- `o_ex_illegal` out 1: unsupported or malformed instruction.

## Operation
- Accept = `i_inst_valid && o_inst_ready`. `o_inst_ready = !o_ex_valid || i_ex_ready`, which is combinational.
- On accept: all `o_ex_*` are loaded and `o_ex_valid` is set to 1.
- No accept while `i_ex_ready=1`: `o_ex_valid` is set to 0.
- `o_ex_valid && !i_ex_ready`: all `o_ex_*` hold bit-stable.
- OP (0110011): op1=rs1, op2=rs2.
  - funct3 mapping: 000→opsel 000 (`sub`=funct7[5]); 001→010; 010→001 (`unsigned`=0); 011→001 (`unsigned`=1); 100→100; 101→011 (`arith`=funct7[5]); 110→101; 111→110.
  - funct7 must be 0000000. 0100000 is also legal for funct3 000 and 101. Anything else is illegal.
- OP-IMM (0010011): op1=rs1, op2=sign-extended inst[31:20], `sub`=0, same funct3 mapping.
  - For 001/101: op2={27'b0, inst[24:20]}; `arith`=inst[30].
  - inst[31:25] must be 0000000 (001) or 0000000/0100000 (101); otherwise illegal.
- LUI (0110111): op1=0, op2={inst[31:12],12'b0}, opsel 000.
- AUIPC (0010111): op1=`i_pc`, op2={inst[31:12],12'b0}, opsel 000.
- Illegal/other opcode: `o_ex_illegal`=1, `o_ex_rd_wen`=0, controls and operands 0. The payload still flows (valid=1).
- `o_ex_rd_wen` = legal && rd!=0. `o_ex_rd_waddr` = inst[11:7].
- Register file: x0 always reads 0 and writes to x0 are dropped. Writes commit on the edge when `i_rd_wen`=1, independent of the handshake.
- Bypass (`BYPASS_EN`=1): if `i_rd_wen` && `i_rd_waddr`==rs && rs!=0, the read returns `i_rd_wdata`. With `BYPASS_EN`=0 the read returns the old value.
- RAW hazards against in-flight instructions are not detected here; that belongs to the hazard unit upstream.

## Timing
- Latency: accept at edge N → payload visible after edge N, through cycle N+1.
- Throughput: 1 instruction/cycle while `i_ex_ready`=1.
- Reset values:
  - `o_ex_valid`=0 and all other `o_ex_*`=0.
  - All registers x1–x31 = 0.
  - `o_inst_ready`=1 in the first cycle after reset.
- Reset mid-operation: the held payload is discarded. A write or accept presented in the reset cycle is ignored.
- Simultaneous accept + writeback to a source register: controlled by `BYPASS_EN` as above. Register state updates on the same edge either way.
- Stall + writeback: the held payload is not re-read. Operands are captured at accept only.

## Structure
- Shared package holds:
  - opcode constants: OP, OP_IMM, LUI, AUIPC;
  - ALU opsel encodings: ADD, SLT, SLL, SRL, XOR, OR, AND;
  - the ALU-control struct shared with `alu`'s driver.
- One sub-module, `regfile`: 2 combinational read ports, 1 write port, synchronous reset, `BYPASS_EN` parameter.
- Decode and immediate logic stay inline.

## Test plan
- Reset, then write x5=0x0000_0007 and x6=0xFFFF_FFF9. Issue `sub x7,x5,x6` → opsel 000, sub=1, op1=7, op2=0xFFFF_FFF9, rd_wen=1, rd=7.
- `srai x1,x6,3` → opsel 011, arith=1, op2=0x0000_0003. `sltiu x2,x5,-1` → opsel 001, unsigned=1, op2=0xFFFF_FFFF.
- `auipc x3,0x12345` at pc 0x100 → op1=0x100, op2=0x1234_5000. `lui x0,1` → rd_wen=0.
- Same-cycle writeback x5=0xAA with `add x8,x5,x5` accepted: `BYPASS_EN`=1 → op1=op2=0xAA; `BYPASS_EN`=0 → 7.
- Hold `i_ex_ready`=0 for 3 cycles with a payload valid → outputs stable and `o_inst_ready`=0. Release → next instruction accepted and no payload lost or duplicated.
- Opcode 0000011 (load) or OP with funct7=0000001 → illegal=1, rd_wen=0. Assert `i_rst` while stalled → `o_ex_valid`=0 next cycle and x5 reads 0.
